imem_uart_loader: RTL
=====================

Name: imem_uart_loader

Overview:
Writer side of the instruction-memory interface. The CPU core's instruction fetch only reads instruction memory. This block receives a program image over a UART line, assembles 32-bit little-endian words, and drives the instruction-memory write port. It runs while the core is held in reset, with `busy` gating the core reset externally.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
ADDR_WIDTH, 14, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
uart_rx  in  1  asynchronous serial input; idle high; 8N1, LSB first.
start  in  1  single-cycle pulse that begins a load session.
wr_en  out  1  instruction-memory write strobe, one cycle per word.
wr_addr  out  ADDR_WIDTH  word address, valid while wr_en=1.
wr_data  out  32  instruction word, valid while wr_en=1.
busy  out  1  high from the accepted start until done or err.
done  out  1  high after the last word is written; held.
err  out  1  framing or length error; held.
word_count  out  ADDR_WIDTH+1  words written in the current or last session.

Behaviour:
- Reset: all outputs 0; the synchronizer flops are set to 1; both FSMs go to idle; any partial word or length is discarded. Reset mid-session aborts with no further writes.
- Input synchronizer: uart_rx passes through a 2-flop synchronizer. All RX logic uses the synchronized value.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a sampled 0.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then re-sample. If the sample is 1, this is a false start: go to RX_IDLE with no byte and no error. If 0, go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, shifted LSB first. Then go to RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: pulse byte_valid for 1 cycle.
    - Sample 0: pulse frame_err for 1 cycle.
    - Either way, return to RX_IDLE.
  - The RX FSM runs regardless of the loader state.
- Loader FSM states: L_IDLE, L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR.
  - start is accepted only in L_IDLE, L_DONE or L_ERR. Accepting it clears done, err and word_count, sets busy, and moves to L_LEN0. start while busy is ignored.
  - Bytes arriving in L_IDLE, L_DONE or L_ERR are ignored.
  - L_LEN0: the byte becomes N[7:0], then go to L_LEN1.
  - L_LEN1: the byte becomes N[15:8].
    - If N=0: go to L_DONE.
    - If N > 2^ADDR_WIDTH: go to L_ERR.
    - Otherwise: go to L_DATA.
  - L_DATA: bytes fill word[7:0], [15:8], [23:16], [31:24] in that order.
    - On the 4th byte_valid, wr_en=1 in the next cycle, with wr_addr = word index (starting at 0) and wr_data = the assembled word.
    - word_count increments in the same cycle as wr_en.
    - After the N-th write, go to L_DONE.
  - L_DONE: done=1, busy=0.
  - frame_err in L_LEN0, L_LEN1 or L_DATA: go to L_ERR with err=1 and busy=0. The partial word is dropped and no write is issued.
  - Transition into L_DONE or L_ERR: done/err rises in the same cycle that busy falls.
- Outputs:
  - wr_addr and wr_data are 0 when wr_en=0.
  - wr_en is never asserted outside L_DATA.
  - word_count saturates at N; there is no wrap-around.
- Byte latency: the decision (write, state change) is taken 1 cycle after the stop-bit sample.

Test Plan:
(Bench uses CLKS_PER_BIT=16; ADDR_WIDTH=4 for the length test.)
1. Reset check: assert rst for 3 cycles with uart_rx=1 → wr_en, busy, done, err and word_count are all 0. Hold rst while driving bytes → no response.
2. Nominal load: start, then bytes 02 00 13 05 10 00 B3 05 B5 00 → two wr_en pulses: addr 0 with 0x00100513, then addr 1 with 0x00B505B3. Then done=1, busy=0, word_count=2.
3. Zero length: start, then 00 00 → done=1 one cycle after the second stop bit; no wr_en.
4. Framing error: start, 01 00 13, then a byte with stop bit 0 → err=1, busy=0, no wr_en. A following start clears err and sets busy.
5. Glitch and overlap: uart_rx low for 3 cycles → no byte, state unchanged. start pulsed mid-session → ignored, and the session completes normally.
6. Length and reset: N=17 (11 00) with ADDR_WIDTH=4 → err=1. Separately, rst after 2 data bytes → all outputs 0; after a new start, the word at addr 0 uses only new bytes.

Source files
------------

// File: rtl/imem_uart_loader.sv
// UART program loader: receives 8N1 bytes, reads a 16-bit little-endian word
// count, assembles 32-bit little-endian words and writes them to instruction
// memory starting at word address 0.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  start,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    // Largest accepted length: the full memory capacity.
    localparam logic [16:0] CAP = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} ld_state_t;

    logic            sync1_q, sync2_q;
    rx_state_t       rx_q, rx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            bvalid_q, bvalid_d;
    logic            ferr_q, ferr_d;

    ld_state_t       ld_q, ld_d;
    logic [15:0]     len_q, len_d;
    logic [23:0]     word_q, word_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic            wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     n_new;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q     <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            bvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            bvalid_q <= bvalid_d;
            ferr_q   <= ferr_d;
        end
    end

    // RX next state: mid-bit sampling, false-start rejection, stop-bit check.
    always_comb begin
        rx_d     = rx_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bvalid_d = 1'b0;
        ferr_d   = 1'b0;
        case (rx_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) rx_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rx_d  = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) rx_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    rx_d     = RX_IDLE;
                    bvalid_d = sync2_q;
                    ferr_d   = !sync2_q;
                end
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q      <= L_IDLE;
            len_q     <= '0;
            word_q    <= '0;
            bidx_q    <= '0;
            wc_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ld_q      <= ld_d;
            len_q     <= len_d;
            word_q    <= word_d;
            bidx_q    <= bidx_d;
            wc_q      <= wc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Loader next state: length header, word assembly, write strobes, status.
    always_comb begin
        ld_d      = ld_q;
        len_d     = len_q;
        word_d    = word_q;
        bidx_d    = bidx_q;
        wc_d      = wc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        n_new     = {shift_q, len_q[7:0]};
        case (ld_q)
            L_IDLE, L_DONE, L_ERR: begin
                if (start) begin
                    ld_d   = L_LEN0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    wc_d   = '0;
                    len_d  = '0;
                    bidx_d = '0;
                end
            end
            L_LEN0: begin
                if (ferr_q) begin
                    ld_d = L_ERR; err_d = 1'b1; busy_d = 1'b0;
                end else if (bvalid_q) begin
                    len_d[7:0] = shift_q;
                    ld_d       = L_LEN1;
                end
            end
            L_LEN1: begin
                if (ferr_q) begin
                    ld_d = L_ERR; err_d = 1'b1; busy_d = 1'b0;
                end else if (bvalid_q) begin
                    len_d = n_new;
                    if (n_new == 16'd0) begin
                        ld_d = L_DONE; done_d = 1'b1; busy_d = 1'b0;
                    end else if ({1'b0, n_new} > CAP) begin
                        ld_d = L_ERR; err_d = 1'b1; busy_d = 1'b0;
                    end else begin
                        ld_d   = L_DATA;
                        bidx_d = '0;
                    end
                end
            end
            L_DATA: begin
                // The final write has just been presented; finish one cycle later
                // so wr_en never coincides with done.
                if (wr_en_q && (17'(wc_q) == {1'b0, len_q})) begin
                    ld_d = L_DONE; done_d = 1'b1; busy_d = 1'b0;
                end else if (ferr_q) begin
                    ld_d = L_ERR; err_d = 1'b1; busy_d = 1'b0;
                end else if (bvalid_q) begin
                    bidx_d = bidx_q + 1'b1;
                    case (bidx_q)
                        2'd0: word_d[7:0]   = shift_q;
                        2'd1: word_d[15:8]  = shift_q;
                        2'd2: word_d[23:16] = shift_q;
                        default: begin
                            if (17'(wc_q) < {1'b0, len_q}) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = wc_q[ADDR_WIDTH-1:0];
                                wr_data_d = {shift_q, word_q};
                                wc_d      = wc_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: ld_d = L_IDLE;
        endcase
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule
